// File: rtl/demux_reg3x1_pkg.sv
// Shared SEL codes, FSM encoding and small helpers for the 3-way registered demux.
package demux_reg3x1_pkg;

    localparam logic [1:0] SEL_Q0       = 2'b00;
    localparam logic [1:0] SEL_Q1       = 2'b01;
    localparam logic [1:0] SEL_Q2       = 2'b10;
    localparam logic [1:0] SEL_INVALIDO = 2'b11;

    typedef enum logic [1:0] {
        VAZIO       = 2'b00,
        PREENCHENDO = 2'b01,
        CHEIO       = 2'b10
    } estado_t;

    // Auto pointer only ever visits Q0..Q2, so 10 wraps back to 00.
    function automatic logic [1:0] proximo_indice(input logic [1:0] idx);
        return (idx == SEL_Q2) ? SEL_Q0 : idx + 2'd1;
    endfunction

    function automatic estado_t estado_de(input logic [2:0] vld);
        if (vld == 3'b000)      return VAZIO;
        else if (vld == 3'b111) return CHEIO;
        else                    return PREENCHENDO;
    endfunction

endpackage

// File: rtl/demux_reg3x1_registrador_4.sv
// 4-bit storage register: async active-high reset, synchronous clear, load enable.
module registrador_4 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] data_q;
    logic [3:0] data_d;

    // Clear takes priority over a load in the same cycle.
    always_comb begin
        data_d = data_q;
        if (clr_i)     data_d = 4'h0;
        else if (en_i) data_d = d_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) data_q <= 4'h0;
        else       data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/demux_reg3x1.sv
// Distributes D into one of three 4-bit registers (manual SEL or auto pointer),
// tracking per-register valid flags and an occupancy FSM. Optional: DEMUX_REG3X1_ERRO_EN.
module demux_reg3x1
    import demux_reg3x1_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] D,
    input  logic [1:0] SEL,
    input  logic       escreve,
    input  logic       modo_auto,
    input  logic       limpa,
    output logic [3:0] Q0,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic [2:0] validos,
    output logic [1:0] indice,
    output logic       cheio,
`ifdef DEMUX_REG3X1_ERRO_EN
    output logic       erro,
`endif
    output estado_t    estado_dbg
);

    // escreve is a single-cycle strobe with no back-pressure: a write is
    // accepted on the edge where escreve=1, limpa=0 and the destination is valid.
    logic [1:0] dest_sel;
    logic       wr_ok;
    logic [2:0] load;

    logic [2:0] validos_q, validos_d;
    logic [1:0] indice_q,  indice_d;
    estado_t    estado_q,  estado_d;

    always_comb begin
        dest_sel = modo_auto ? indice_q : SEL;
        wr_ok    = escreve && !limpa && (dest_sel != SEL_INVALIDO);
        load     = 3'b000;
        if (wr_ok) begin
            case (dest_sel)
                SEL_Q0:  load = 3'b001;
                SEL_Q1:  load = 3'b010;
                SEL_Q2:  load = 3'b100;
                default: load = 3'b000;
            endcase
        end
    end

    always_comb begin
        validos_d = limpa ? 3'b000 : (validos_q | load);
        indice_d  = indice_q;
        estado_d  = estado_q;
        if (limpa) begin
            indice_d = SEL_Q0;
            estado_d = VAZIO;
        end else if (wr_ok) begin
            if (modo_auto) indice_d = proximo_indice(indice_q);
            estado_d = estado_de(validos_d);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            validos_q <= 3'b000;
            indice_q  <= SEL_Q0;
            estado_q  <= VAZIO;
        end else begin
            validos_q <= validos_d;
            indice_q  <= indice_d;
            estado_q  <= estado_d;
        end
    end

    registrador_4 u_reg_q0 (
        .clk_i(clock), .rst_i(reset), .clr_i(limpa), .en_i(load[0]), .d_i(D), .q_o(Q0)
    );
    registrador_4 u_reg_q1 (
        .clk_i(clock), .rst_i(reset), .clr_i(limpa), .en_i(load[1]), .d_i(D), .q_o(Q1)
    );
    registrador_4 u_reg_q2 (
        .clk_i(clock), .rst_i(reset), .clr_i(limpa), .en_i(load[2]), .d_i(D), .q_o(Q2)
    );

`ifdef DEMUX_REG3X1_ERRO_EN
    logic erro_q;

    // Registered so the flag shows up for exactly the cycle after the bad write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) erro_q <= 1'b0;
        else       erro_q <= escreve && !limpa && !modo_auto && (SEL == SEL_INVALIDO);
    end

    assign erro = erro_q;
`endif

    assign validos    = validos_q;
    assign indice     = indice_q;
    assign cheio      = (estado_q == CHEIO);
    assign estado_dbg = estado_q;

endmodule

// File: tb/tb_demux_reg3x1.sv
// Bench for demux_reg3x1: directed vector table, async-reset sequence, random vs. model.
module tb_demux_reg3x1;
    import demux_reg3x1_pkg::*;

    logic       clock, reset;
    logic [3:0] D;
    logic [1:0] SEL;
    logic       escreve, modo_auto, limpa;
    logic [3:0] Q0, Q1, Q2;
    logic [2:0] validos;
    logic [1:0] indice;
    logic       cheio;
    estado_t    estado_dbg;
`ifdef DEMUX_REG3X1_ERRO_EN
    logic       erro;
`endif

    demux_reg3x1 dut (
        .clock(clock), .reset(reset), .D(D), .SEL(SEL), .escreve(escreve),
        .modo_auto(modo_auto), .limpa(limpa), .Q0(Q0), .Q1(Q1), .Q2(Q2),
        .validos(validos), .indice(indice), .cheio(cheio),
`ifdef DEMUX_REG3X1_ERRO_EN
        .erro(erro),
`endif
        .estado_dbg(estado_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    int vectors     = 0;
    int miscompares = 0;

    // behavioural reference model
    logic [3:0] m_q [3];
    logic [2:0] m_vld;
    int         m_idx;
    logic       m_erro;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) m_q[i] = 4'h0;
        m_vld  = 3'b000;
        m_idx  = 0;
        m_erro = 1'b0;
    endfunction

    function automatic void model_step(input logic esc, input logic aut, input logic [1:0] sel,
                                       input logic [3:0] d, input logic clr);
        int dest;
        m_erro = esc && !clr && !aut && (sel == 2'd3);
        if (clr) begin
            for (int i = 0; i < 3; i++) m_q[i] = 4'h0;
            m_vld = 3'b000;
            m_idx = 0;
        end else if (esc) begin
            dest = aut ? m_idx : int'(sel);
            if (dest < 3) begin
                m_q[dest]   = d;
                m_vld[dest] = 1'b1;
                if (aut) m_idx = (m_idx + 1) % 3;
            end
        end
    endfunction

    function automatic estado_t exp_estado(input logic [2:0] vld);
        if (vld == 3'b000)      return VAZIO;
        else if (vld == 3'b111) return CHEIO;
        else                    return PREENCHENDO;
    endfunction

    // scoreboard helpers
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] q0, input logic [3:0] q1,
                               input logic [3:0] q2, input logic [2:0] vld, input logic [1:0] idx,
                               input logic ch, input logic er);
        chk({tag, ".Q0"},      {4'h0, Q0}, {4'h0, q0});
        chk({tag, ".Q1"},      {4'h0, Q1}, {4'h0, q1});
        chk({tag, ".Q2"},      {4'h0, Q2}, {4'h0, q2});
        chk({tag, ".validos"}, {5'h0, validos}, {5'h0, vld});
        chk({tag, ".indice"},  {6'h0, indice},  {6'h0, idx});
        chk({tag, ".cheio"},   {7'h0, cheio},   {7'h0, ch});
        chk({tag, ".estado"},  {6'h0, estado_dbg}, {6'h0, exp_estado(vld)});
`ifdef DEMUX_REG3X1_ERRO_EN
        chk({tag, ".erro"},    {7'h0, erro},    {7'h0, er});
`else
        if (er === 1'bx) $display("unexpected X in expected erro");
`endif
    endtask

    task automatic chk_model(input string tag);
        chk_outputs(tag, m_q[0], m_q[1], m_q[2], m_vld, 2'(m_idx), (m_vld == 3'b111), m_erro);
    endtask

    // driver
    task automatic drive(input logic esc, input logic aut, input logic [1:0] sel,
                         input logic [3:0] d, input logic clr);
        escreve   = esc;
        modo_auto = aut;
        SEL       = sel;
        D         = d;
        limpa     = clr;
    endtask

    typedef struct {
        logic       esc, aut, clr;
        logic [1:0] sel;
        logic [3:0] d;
        logic [3:0] q0, q1, q2;
        logic [2:0] vld;
        logic [1:0] idx;
        logic       ch, er;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // esc aut clr sel d | q0 q1 q2 vld idx cheio erro
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h3, 4'h3, 4'h0, 4'h0, 3'b001, 2'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h5, 4'h3, 4'h5, 4'h0, 3'b011, 2'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h9, 4'h3, 4'h5, 4'h9, 3'b111, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h7, 4'h7, 4'h5, 4'h9, 3'b111, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'hE, 4'h0, 4'h0, 4'h0, 3'b000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 4'hA, 4'h0, 4'h0, 4'hA, 3'b100, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd3, 4'hF, 4'h0, 4'h0, 4'hA, 3'b100, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0, 4'h0, 4'hA, 3'b100, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'hC, 4'hC, 4'h0, 4'hA, 3'b101, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h4, 4'h4, 4'h0, 4'hA, 3'b101, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'hB, 4'h4, 4'hB, 4'hA, 3'b111, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h6, 4'h4, 4'h6, 4'hA, 3'b111, 2'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 2'd0, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
        model_clear();
        #1;
        chk_outputs("reset", 4'h0, 4'h0, 4'h0, 3'b000, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].esc, tbl[i].aut, tbl[i].sel, tbl[i].d, tbl[i].clr);
            model_step(tbl[i].esc, tbl[i].aut, tbl[i].sel, tbl[i].d, tbl[i].clr);
            @(posedge clock);
            @(negedge clock);
            chk_outputs($sformatf("tbl%0d", i), tbl[i].q0, tbl[i].q1, tbl[i].q2,
                        tbl[i].vld, tbl[i].idx, tbl[i].ch, tbl[i].er);
        end

        // fill to full, then async reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'd0, 4'(i + 1), 1'b0);
            @(posedge clock);
            @(negedge clock);
        end
        drive(1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
        chk_outputs("pre_rst", 4'h1, 4'h2, 4'h3, 3'b111, 2'd0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_outputs("async_rst", 4'h0, 4'h0, 4'h0, 3'b000, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'd0, 4'h8, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk_outputs("rst_abort", 4'h0, 4'h0, 4'h0, 3'b000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        model_clear();
        drive(1'b1, 1'b1, 2'd0, 4'h2, 1'b0);
        model_step(1'b1, 1'b1, 2'd0, 4'h2, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk_outputs("post_rst", 4'h2, 4'h0, 4'h0, 3'b001, 2'd1, 1'b0, 1'b0);

        // refill to full, then a fourth auto write overwrites Q0 and stays full
        for (int i = 0; i < 3; i++) begin
            logic [3:0] dv;
            dv = (i == 2) ? 4'h7 : 4'(i + 4);
            drive(1'b1, 1'b1, 2'd0, dv, 1'b0);
            model_step(1'b1, 1'b1, 2'd0, dv, 1'b0);
            @(posedge clock);
            @(negedge clock);
        end
        chk_outputs("overwrite_full", 4'h7, 4'h4, 4'h5, 3'b111, 2'd1, 1'b1, 1'b0);

        // randomized stimulus vs. model
        for (int n = 0; n < 400; n++) begin
            logic esc, aut, clr;
            logic [1:0] sel;
            logic [3:0] d;
            esc = ($urandom_range(0, 3) != 0);
            aut = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            d   = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 15) == 0);
            drive(esc, aut, sel, d, clr);
            model_step(esc, aut, sel, d, clr);
            @(posedge clock);
            @(negedge clock);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_reg3x1.md
DEMUX_REG3X1 -- requirements
Module: demux_reg3x1

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port D, input, 4 bits: data to distribute.
REQ-004 SHALL have port SEL, input, 2 bits: destination in manual mode (00→Q0, 01→Q1, 10→Q2, 11→invalid).
REQ-005 SHALL have port escreve, input, 1 bit: write strobe, sampled each cycle.
REQ-006 SHALL have port modo_auto, input, 1 bit: 1 = destination from internal pointer; 0 = destination from SEL.
REQ-007 SHALL have port limpa, input, 1 bit: synchronous clear of registers, valid flags, pointer and FSM.
REQ-008 SHALL have ports Q0, Q1, Q2, output, 4 bits each: stored register contents.
REQ-009 SHALL have port validos, output, 3 bits: bit i = Qi written since last clear.
REQ-010 SHALL have port indice, output, 2 bits: current auto pointer (00, 01 or 10 only).
REQ-011 SHALL have port cheio, output, 1 bit: high when validos = 111.

Function
REQ-012 SHALL, when escreve=1 and the destination is valid, load D into the destination register at the next rising edge (1-cycle latency) and set its validos bit.
REQ-013 SHALL leave non-destination registers unchanged on every write.
REQ-014 SHALL, in manual mode with SEL=11, ignore the write: no register, flag or pointer change.
REQ-015 SHALL, in auto mode, use indice as destination and advance it on each accepted write 00→01→10→00 (wrap).
REQ-016 SHALL not change indice in manual mode.
REQ-017 SHALL implement FSM VAZIO (validos=000), PREENCHENDO (some but not all set), CHEIO (validos=111); transitions follow validos after each write; limpa → VAZIO from any state.
REQ-018 SHALL assert cheio combinationally from state CHEIO only.
REQ-019 SHALL, in CHEIO, still accept writes (overwrite) and remain in CHEIO.
REQ-020 SHALL give limpa priority over escreve in the same cycle: clear wins, data discarded.
REQ-021 SHALL apply a modo_auto change from the next cycle; indice is retained across mode changes.

Reset
REQ-022 SHALL, on reset=1, immediately drive Q0=Q1=Q2=0000, validos=000, indice=00, cheio=0, FSM=VAZIO, independent of clock.
REQ-023 SHALL abort any write coinciding with reset; first write after release goes to Q0 in auto mode.

Configuration
REQ-024 SHALL, with macro DEMUX_REG3X1_ERRO_EN defined, add output erro (1 bit), pulsed high for exactly one cycle after a manual-mode write with SEL=11; reset value 0.
REQ-025 SHALL, without DEMUX_REG3X1_ERRO_EN, omit port erro; invalid writes are silently ignored per REQ-014.

Structure
REQ-026 SHALL place SEL codes (SEL_Q0, SEL_Q1, SEL_Q2, SEL_INVALIDO) and FSM state encodings in the shared package demux_reg3x1_pkg.
REQ-027 SHALL instantiate sub-module registrador_4 (4-bit register, async active-high reset, synchronous clear, load enable) three times for Q0..Q2.

Verification
REQ-028 Bench SHALL cover: reset, then auto mode, writes D=3,5,9 → Q0=3, Q1=5, Q2=9, validos=111, cheio=1 after the third edge, indice=00.
REQ-029 Bench SHALL cover: manual, SEL=10, D=A, escreve=1 → Q2=A, validos=100, Q0/Q1 remain 0, indice=00.
REQ-030 Bench SHALL cover: manual, SEL=11, D=F → no change; with DEMUX_REG3X1_ERRO_EN, erro=1 for one cycle.
REQ-031 Bench SHALL cover: limpa=1 and escreve=1 together in CHEIO → all Q=0, validos=000, cheio=0, indice=00.
REQ-032 Bench SHALL cover: reset asserted mid-cycle between edges → outputs zero before next edge; fourth auto write after full (D=7) → Q0=7, cheio stays 1.
